// File: rtl/column_slice_renderer_pkg.sv
// Shared constants, state encoding and height helpers for the column slice renderer.
package column_slice_renderer_pkg;

   localparam logic [7:0] SCREEN_W = 8'd160;
   localparam logic [6:0] SCREEN_H = 7'd120;
   localparam logic [7:0] LAST_COL = SCREEN_W - 8'd1;
   localparam logic [6:0] LAST_ROW = SCREEN_H - 7'd1;

   localparam logic [2:0] CEIL_COLOUR  = 3'b001;
   localparam logic [2:0] WALL_COLOUR  = 3'b110;
   localparam logic [2:0] FLOOR_COLOUR = 3'b010;

   localparam logic [9:0] CALC_TIMEOUT_CYCLES = 10'd1023;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_REQ       = 3'd1,
      S_WAIT_CALC = 3'd2,
      S_DRAW      = 3'd3,
      S_NEXT_COL  = 3'd4,
      S_DONE      = 3'd5
   } state_t;

   function automatic logic [6:0] clamp_height(input logic [6:0] slice);
      return (slice > SCREEN_H) ? SCREEN_H : slice;
   endfunction

   // Odd leftover space goes to the floor, so the wall sits half a row high.
   function automatic logic [6:0] wall_top(input logic [6:0] h);
      logic [6:0] space;
      space = SCREEN_H - h;
      return {1'b0, space[6:1]};
   endfunction

endpackage

// File: rtl/column_slice_renderer_slice_colour_decode.sv
// Combinational row colour for one column: ceiling above the wall, wall, then floor.
module slice_colour_decode
   import column_slice_renderer_pkg::*;
(
   input  logic [6:0] h,
   input  logic [6:0] top,
   input  logic [6:0] y,
   output logic [2:0] colour
);

   logic [7:0] wall_end;

   // Widened so top+h never wraps when the wall fills the whole column.
   assign wall_end = {1'b0, top} + {1'b0, h};

   always_comb begin
      colour = FLOOR_COLOUR;
      if (y < top) begin
         colour = CEIL_COLOUR;
      end else if ({1'b0, y} < wall_end) begin
         colour = WALL_COLOUR;
      end
   end

endmodule

// File: rtl/column_slice_renderer.sv
// Column slice renderer: requests a wall height per column and paints 120 rows to the VGA adapter.
// Define CALC_TIMEOUT_EN to add a watchdog that draws an empty column if the calculator never answers.
module column_slice_renderer
   import column_slice_renderer_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic       start_frame,
   input  logic [6:0] slice_size,
   input  logic       end_calc,
   output logic       begin_calc,
   output logic [7:0] column_count,
   output logic [7:0] x,
   output logic [6:0] y,
   output logic [2:0] colour,
   output logic       plot,
   output logic       busy,
   output logic       frame_done
);

   state_t     state_q, state_d;
   logic [7:0] col_q, col_d;
   logic [6:0] y_q, y_d;
   logic [6:0] h_q, h_d;
   logic [6:0] top_q, top_d;
   logic [2:0] row_colour;
`ifdef CALC_TIMEOUT_EN
   logic [9:0] wait_cnt_q, wait_cnt_d;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
         col_q   <= 8'd0;
         y_q     <= 7'd0;
         h_q     <= 7'd0;
         top_q   <= 7'd0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         y_q     <= y_d;
         h_q     <= h_d;
         top_q   <= top_d;
      end
   end

`ifdef CALC_TIMEOUT_EN
   always_ff @(posedge clock) begin
      if (reset) begin
         wait_cnt_q <= 10'd0;
      end else begin
         wait_cnt_q <= wait_cnt_d;
      end
   end
`endif

   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      y_d     = y_q;
      h_d     = h_q;
      top_d   = top_q;
`ifdef CALC_TIMEOUT_EN
      wait_cnt_d = wait_cnt_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start_frame) begin
               col_d   = 8'd0;
               state_d = S_REQ;
            end
         end
         S_REQ: begin
`ifdef CALC_TIMEOUT_EN
            wait_cnt_d = 10'd0;
`endif
            state_d = S_WAIT_CALC;
         end
         // A late answer in the timeout cycle still wins over the watchdog.
         S_WAIT_CALC: begin
            if (end_calc) begin
               h_d     = clamp_height(slice_size);
               top_d   = wall_top(clamp_height(slice_size));
               y_d     = 7'd0;
               state_d = S_DRAW;
`ifdef CALC_TIMEOUT_EN
            end else if (wait_cnt_q == CALC_TIMEOUT_CYCLES - 10'd1) begin
               h_d     = 7'd0;
               top_d   = wall_top(7'd0);
               y_d     = 7'd0;
               state_d = S_DRAW;
            end else begin
               wait_cnt_d = wait_cnt_q + 10'd1;
`endif
            end
         end
         S_DRAW: begin
            if (y_q == LAST_ROW) begin
               state_d = S_NEXT_COL;
            end else begin
               y_d = y_q + 7'd1;
            end
         end
         S_NEXT_COL: begin
            if (col_q == LAST_COL) begin
               state_d = S_DONE;
            end else begin
               col_d   = col_q + 8'd1;
               state_d = S_REQ;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   slice_colour_decode u_decode (
      .h      (h_q),
      .top    (top_q),
      .y      (y_q),
      .colour (row_colour)
   );

   assign begin_calc   = (state_q == S_REQ);
   assign plot         = (state_q == S_DRAW);
   assign busy         = (state_q != S_IDLE);
   assign frame_done   = (state_q == S_DONE);
   assign column_count = col_q;
   assign x            = col_q;
   assign y            = y_q;
   assign colour       = plot ? row_colour : 3'b000;

endmodule

// File: tb/tb_column_slice_renderer.sv
// Self-checking bench for column_slice_renderer: stub calculator, pixel monitor and frame-level totals.
module tb_column_slice_renderer;

   logic       clock;
   logic       reset;
   logic       start_frame;
   logic [6:0] slice_size;
   logic       end_calc;
   logic       begin_calc;
   logic [7:0] column_count;
   logic [7:0] x;
   logic [6:0] y;
   logic [2:0] colour;
   logic       plot;
   logic       busy;
   logic       frame_done;

   column_slice_renderer dut (
      .clock        (clock),
      .reset        (reset),
      .start_frame  (start_frame),
      .slice_size   (slice_size),
      .end_calc     (end_calc),
      .begin_calc   (begin_calc),
      .column_count (column_count),
      .x            (x),
      .y            (y),
      .colour       (colour),
      .plot         (plot),
      .busy         (busy),
      .frame_done   (frame_done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   int slice_tab [160];
   int lat_tab   [160];
   int hexp_tab  [160];
   int silent_col = -1;
   bit spurious_en = 1'b0;

   int begin_count, draw_count, row_idx, col_bad, plot_count, done_count, busy_cycles;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Reference colour straight from the row rules: ceiling, h wall rows centred (floored), floor.
   function automatic logic [2:0] modelColour(input int h, input int row);
      int top;
      top = (120 - h) / 2;
      if (row < top) return 3'b001;
      if (row < top + h) return 3'b110;
      return 3'b010;
   endfunction

   // Stub calculator answers lat_tab cycles after each begin_calc and optionally injects stray pulses.
   initial begin : stub_calc
      int cnt;
      int pend_col;
      bit pending;
      end_calc   = 1'b0;
      slice_size = 7'd0;
      pending    = 1'b0;
      cnt        = 0;
      pend_col   = 0;
      forever begin
         @(negedge clock);
         end_calc = 1'b0;
         if (reset) begin
            pending = 1'b0;
         end else if (pending) begin
            if (cnt == 0) begin
               pending = 1'b0;
               if (pend_col != silent_col) begin
                  end_calc   = 1'b1;
                  slice_size = 7'(slice_tab[pend_col]);
               end
            end else begin
               cnt--;
            end
         end else if (begin_calc) begin
            pending  = 1'b1;
            pend_col = int'(column_count) % 160;
            cnt      = lat_tab[pend_col] - 1;
         end else if (spurious_en && (plot || !busy) && $urandom_range(0, 5) == 0) begin
            end_calc   = 1'b1;
            slice_size = 7'($urandom_range(0, 127));
         end
      end
   end

   // Pixel monitor: every column must be 120 consecutive correct rows, in column order.
   always @(negedge clock) begin
      if (reset) begin
         row_idx = 0;
         col_bad = 0;
      end else begin
         if (busy) busy_cycles++;
         if (frame_done) done_count++;
         if (begin_calc) begin
            checkOutput("begin_col", 32'(column_count), 32'(begin_count));
            begin_count++;
         end
         if (plot) begin
            if (row_idx == 0) checkOutput("draw_col", 32'(column_count), 32'(draw_count));
            if (y !== 7'(row_idx) || x !== 8'(draw_count) ||
                colour !== modelColour(hexp_tab[draw_count % 160], row_idx)) col_bad++;
            plot_count++;
            row_idx++;
            if (row_idx == 120) begin
               checkOutput("col_pixels_bad", 32'(col_bad), 32'd0);
               col_bad = 0;
               row_idx = 0;
               draw_count++;
            end
         end else if (row_idx != 0) begin
            checkOutput("plot_run", 32'(row_idx), 32'd120);
            row_idx = 0;
            col_bad = 0;
            draw_count++;
         end
      end
   end

   task automatic clearCounters();
      begin_count = 0;
      draw_count  = 0;
      row_idx     = 0;
      col_bad     = 0;
      plot_count  = 0;
      done_count  = 0;
      busy_cycles = 0;
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_begin_calc"}, 32'(begin_calc), 32'd0);
      checkOutput({tag, "_plot"}, 32'(plot), 32'd0);
      checkOutput({tag, "_frame_done"}, 32'(frame_done), 32'd0);
      checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
      checkOutput({tag, "_column_count"}, 32'(column_count), 32'd0);
      checkOutput({tag, "_x"}, 32'(x), 32'd0);
      checkOutput({tag, "_y"}, 32'(y), 32'd0);
      checkOutput({tag, "_colour"}, 32'(colour), 32'd0);
   endtask

   // Runs one full frame from the current tables and checks the frame-level totals.
   task automatic applyStimulus(input string tag, input bit spurious);
      int exp_busy;
      int cyc;
      exp_busy = 1;
      for (int i = 0; i < 160; i++) exp_busy += 122 + lat_tab[i];
      @(negedge clock);
      clearCounters();
      spurious_en = spurious;
      start_frame = 1'b1;
      @(negedge clock);
      start_frame = 1'b0;
      cyc = 0;
      while (!frame_done && cyc < exp_busy + 500) begin
         @(negedge clock);
         start_frame = spurious && busy && !frame_done && ($urandom_range(0, 9) == 0);
         cyc++;
      end
      start_frame = 1'b0;
      checkOutput({tag, "_frame_done_seen"}, 32'(frame_done), 32'd1);
      repeat (4) @(negedge clock);
      spurious_en = 1'b0;
      checkOutput({tag, "_begin_pulses"}, 32'(begin_count), 32'd160);
      checkOutput({tag, "_columns_drawn"}, 32'(draw_count), 32'd160);
      checkOutput({tag, "_plot_cycles"}, 32'(plot_count), 32'd19200);
      checkOutput({tag, "_frame_done_pulses"}, 32'(done_count), 32'd1);
      checkOutput({tag, "_busy_cycles"}, 32'(busy_cycles), 32'(exp_busy));
      checkOutput({tag, "_idle_after"}, 32'(busy), 32'd0);
   endtask

   initial begin : main
      int cyc;
      int saved_begins;
      reset       = 1'b1;
      start_frame = 1'b0;
      clearCounters();
      for (int i = 0; i < 160; i++) begin
         slice_tab[i] = 40;
         lat_tab[i]   = 12;
         hexp_tab[i]  = 40;
      end
      repeat (3) @(negedge clock);
      checkResetState("por");
      reset = 1'b0;
      repeat (5) @(negedge clock);
      checkOutput("no_start_idle", 32'(busy), 32'd0);

      $display("[TB] frame 1: slice 40, latency 12");
      applyStimulus("f1", 1'b0);

      $display("[TB] frame 2: random heights, boundary columns, stray pulses");
      for (int i = 0; i < 160; i++) begin
         slice_tab[i] = $urandom_range(0, 127);
         lat_tab[i]   = $urandom_range(1, 8);
      end
      slice_tab[0] = 0;
      slice_tab[1] = 120;
      slice_tab[2] = 127;
      slice_tab[3] = 31;
      for (int i = 0; i < 160; i++) hexp_tab[i] = (slice_tab[i] > 120) ? 120 : slice_tab[i];
`ifdef CALC_TIMEOUT_EN
      silent_col  = 5;
      lat_tab[5]  = int'(column_slice_renderer_pkg::CALC_TIMEOUT_CYCLES);
      hexp_tab[5] = 0;
`endif
      applyStimulus("f2", 1'b1);
      silent_col = -1;

      $display("[TB] frame 3: reset during column 37 draw");
      for (int i = 0; i < 160; i++) begin
         slice_tab[i] = $urandom_range(0, 127);
         lat_tab[i]   = $urandom_range(1, 4);
         hexp_tab[i]  = (slice_tab[i] > 120) ? 120 : slice_tab[i];
      end
      @(negedge clock);
      clearCounters();
      start_frame = 1'b1;
      @(negedge clock);
      start_frame = 1'b0;
      cyc = 0;
      while (!(plot && column_count == 8'd37 && y == 7'd50) && cyc < 10000) begin
         @(negedge clock);
         cyc++;
      end
      checkOutput("reached_col37_draw", 32'(cyc < 10000), 32'd1);
      reset = 1'b1;
      @(negedge clock);
      checkResetState("midreset");
      @(negedge clock);
      reset = 1'b0;
      saved_begins = begin_count;
      repeat (10) @(negedge clock);
      checkOutput("after_reset_idle", 32'(busy), 32'd0);
      checkOutput("after_reset_no_begin", 32'(begin_count), 32'(saved_begins));

      $display("[TB] frame 4: restart after reset");
      for (int i = 0; i < 160; i++) lat_tab[i] = 1;
      applyStimulus("f4", 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/column_slice_renderer.md
Name: column_slice_renderer

Overview:
- Initiator and consumer for the per-column slice-size calculator; sits between it and the VGA adapter.
- On start_frame, steps column_count 0..159 and pulses begin_calc for each column.
- Waits for end_calc, latches slice_size, then draws that 120-pixel column as ceiling, wall and floor.
- Pulses frame_done after column 159 is drawn.

Parameters:
- SCREEN_W, 160, columns per frame (column_count range 0..SCREEN_W-1).
- SCREEN_H, 120, rows per column; maximum wall height after clamping.
- CEIL_COLOUR, 3'b001, colour for rows above the wall.
- WALL_COLOUR, 3'b110, colour for wall rows.
- FLOOR_COLOUR, 3'b010, colour for rows below the wall.
- CALC_TIMEOUT_CYCLES, 1023, watchdog limit; used only when the optional feature is compiled in.

Ports:
- clock  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-high; one clock domain only.
- start_frame  in  1  request to render one frame; sampled only in S_IDLE.
- slice_size  in  7  wall height from the calculator; valid only in the cycle end_calc=1.
- end_calc  in  1  single-cycle pulse: calculation for the current column is complete.
- begin_calc  out  1  single-cycle pulse starting the calculation for column_count.
- column_count  out  8  column currently being calculated or drawn.
- x  out  8  pixel x; equals column_count.
- y  out  7  pixel y.
- colour  out  3  pixel colour.
- plot  out  1  pixel write strobe to the VGA adapter.
- busy  out  1  high in every state except S_IDLE.
- frame_done  out  1  single-cycle pulse when the frame is complete.

Behaviour:
- All outputs are driven directly from registers or a decode of the state register.
- Reset values: begin_calc, plot, frame_done and busy = 0; column_count, x and y = 0; colour = 0; state = S_IDLE.
- Reset takes effect from any state, including mid-calculation or mid-draw. It aborts the frame and issues no further begin_calc.
- State machine:
  - S_IDLE: if start_frame, set column_count=0 and go to S_REQ.
  - S_REQ: begin_calc=1 for exactly one cycle; then S_WAIT_CALC.
  - S_WAIT_CALC: hold column_count stable. When end_calc=1, latch h=min(slice_size, SCREEN_H), compute top=(SCREEN_H-h)>>1, clear the y counter and go to S_DRAW.
  - S_DRAW: plot=1 every cycle for y=0..SCREEN_H-1, so exactly 120 consecutive plot cycles.
    - colour = CEIL_COLOUR if y<top.
    - colour = WALL_COLOUR if top<=y<top+h.
    - colour = FLOOR_COLOUR otherwise.
    - After y=SCREEN_H-1, go to S_NEXT_COL.
  - S_NEXT_COL: if column_count==SCREEN_W-1 go to S_DONE; else increment column_count and go to S_REQ.
  - S_DONE: frame_done=1 for one cycle; then S_IDLE.
- end_calc is ignored outside S_WAIT_CALC.
- start_frame is ignored while busy. It is not queued.
- Per-column latency = 1 (S_REQ) + calculator latency + 120 (S_DRAW) + 1 (S_NEXT_COL).
- Wall height boundaries:
  - h=0: top=60, no wall rows.
  - slice_size 120..127: clamped to 120, whole column is wall.
  - Odd h floors top; e.g. h=31 gives top=44 and wall rows 44..74.
- Arithmetic is unsigned, 7-bit for h and top, 8-bit for the top+h compare.

Optional Feature:
- CALC_TIMEOUT_EN defined:
  - A 10-bit counter runs in S_WAIT_CALC.
  - If it reaches CALC_TIMEOUT_CYCLES without end_calc, h is forced to 0 and the block goes to S_DRAW (ceiling and floor only).
  - If end_calc arrives in the same cycle as the timeout, end_calc wins.
- CALC_TIMEOUT_EN undefined: no counter; S_WAIT_CALC waits indefinitely.

Decomposition:
- Shared package:
  - SCREEN_W, SCREEN_H.
  - Colour constants.
  - State encoding localparams S_IDLE..S_DONE, 3 bits.
- One natural sub-module: slice_colour_decode.
  - Combinational.
  - Inputs h, top, y; output colour.
  - Reusable by the future textured-wall renderer.

Test Plan:
- Stub calculator returns end_calc 12 cycles after each begin_calc, slice_size=40. Start a frame -> 160 begin_calc pulses and 160×120 plot cycles. Every column: rows 0..39 ceiling, 40..79 wall, 80..119 floor. Exactly one frame_done pulse.
- slice_size=0, 120 and 127 on successive columns -> all-ceiling/floor split at row 60; all-wall; all-wall (clamped).
- slice_size=31 -> wall rows 44..74 exactly.
- Spurious end_calc during S_DRAW and S_IDLE, and start_frame pulses while busy -> no change to column sequence, plot count or frame length.
- Assert reset during column 37 in S_DRAW -> next cycle all outputs at reset values. A new start_frame restarts at column_count=0.
- CALC_TIMEOUT_EN defined, CALC_TIMEOUT_CYCLES=20, stub never answers column 5 -> after 20 cycles column 5 is drawn with rows 0..59 ceiling and 60..119 floor, then column 6 is requested.
